// File: rtl/buf_stream_reader.sv
// Read-side sequencer for the dual-port feature buffer: issues len wrapped reads from base_addr,
// absorbs the 1-cycle read latency and streams words through a 3-entry FIFO over valid/ready.
module buf_stream_reader #(
  parameter int unsigned WWORD = 32,
  parameter int unsigned AW    = 12,
  parameter int unsigned DEPTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [AW-1:0]    len,
  output logic             busy,
  output logic             done,
  output logic             rd_cen,
  output logic [AW-1:0]    rd_addr,
  input  logic [WWORD-1:0] rd_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WWORD-1:0] m_data,
  output logic             m_last
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t         state_q;
  logic [AW-1:0]  addr_q, addr_d;
  logic [AW-1:0]  len_q;
  logic [AW-1:0]  issued_q;
  logic           inflight_q;
  logic           inflight_last_q;

  logic [WWORD:0] fifo_q [3];
  logic [1:0]     wr_ptr_q, rd_ptr_q;
  logic [1:0]     count_q, count_d;

  logic [2:0]     occ;
  logic           issue;
  logic           issue_last;
  logic           push;
  logic           pop;
  logic [WWORD:0] head;

  // Issue decision uses only registered occupancy, so m_ready never reaches rd_cen combinationally.
  always_comb begin
    occ        = {1'b0, count_q} + {2'b00, inflight_q};
    issue      = (state_q == S_RUN) && (occ < 3'd3);
    issue_last = (issued_q == (len_q - AW'(1)));
    addr_d     = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + AW'(1);
    push       = inflight_q;
    head       = fifo_q[rd_ptr_q];
    pop        = (count_q != 2'd0) && m_ready;
    count_d    = count_q;
    if (push && !pop)      count_d = count_q + 2'd1;
    else if (!push && pop) count_d = count_q - 2'd1;
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign rd_cen  = ~issue;
  assign rd_addr = addr_q;
  assign m_valid = (count_q != 2'd0);
  assign m_data  = head[WWORD-1:0];
  assign m_last  = m_valid & head[WWORD];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      len_q           <= '0;
      issued_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      for (int unsigned i = 0; i < 3; i++) fifo_q[i] <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            addr_q   <= base_addr;
            len_q    <= len;
            issued_q <= '0;
            state_q  <= (len != '0) ? S_RUN : S_DONE;
          end
        end
        S_RUN: begin
          if (issue) begin
            addr_q   <= addr_d;
            issued_q <= issued_q + AW'(1);
            if (issue_last) state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!inflight_q && pop && head[WWORD]) state_q <= S_DONE;
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase

      inflight_q      <= issue;
      inflight_last_q <= issue & issue_last;

      if (push) begin
        fifo_q[wr_ptr_q] <= {inflight_last_q, rd_data};
        wr_ptr_q         <= (wr_ptr_q == 2'd2) ? 2'd0 : wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_q <= (rd_ptr_q == 2'd2) ? 2'd0 : rd_ptr_q + 2'd1;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_buf_stream_reader.sv
// Directed bench for buf_stream_reader with a 1-cycle-latency buffer model and hand-computed timing.
module tb_buf_stream_reader;

  localparam int unsigned WWORD = 32;
  localparam int unsigned AW    = 12;
  localparam int unsigned DEPTH = 24;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [AW-1:0]    base_addr;
  logic [AW-1:0]    len;
  logic             busy, done, rd_cen, m_valid, m_last, m_ready;
  logic [AW-1:0]    rd_addr;
  logic [WWORD-1:0] rd_data = '0;
  logic [WWORD-1:0] m_data;

  int errors = 0;
  int checks = 0;

  buf_stream_reader #(.WWORD(WWORD), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .rd_cen(rd_cen), .rd_addr(rd_addr), .rd_data(rd_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memw(input int unsigned a);
    return 32'h5A00_0000 + a * 32'h0001_0203;
  endfunction

  always @(posedge clk)
    if (!rd_cen) rd_data <= (rd_addr < AW'(DEPTH)) ? memw(int'(rd_addr)) : 32'hDEAD_BEEF;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"},   32'(busy), 0);
    chk({tag, "_done"},   32'(done), 0);
    chk({tag, "_rdcen"},  32'(rd_cen), 1);
    chk({tag, "_rdaddr"}, 32'(rd_addr), 0);
    chk({tag, "_mvalid"}, 32'(m_valid), 0);
    chk({tag, "_mlast"},  32'(m_last), 0);
    chk({tag, "_mdata"},  m_data, 0);
  endtask

  task automatic beat(input string tag, input int unsigned a, input logic last);
    chk({tag, "_valid"}, 32'(m_valid), 1);
    chk({tag, "_data"},  m_data, memw(a));
    chk({tag, "_last"},  32'(m_last), 32'(last));
  endtask

  initial begin
    int unsigned k, issued, acc;
    logic        hold, got_done;
    logic [31:0] held;

    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; m_ready = 1'b0;
    tick(); tick();
    chk_reset_vals("reset");
    rst = 1'b0;
    tick();

    // base=0, len=4, m_ready=1
    m_ready = 1'b1; base_addr = 12'd0; len = 12'd4; start = 1'b1;
    tick(); start = 1'b0;                                           // N+1
    chk("t1_n1_cen", 32'(rd_cen), 0); chk("t1_n1_addr", 32'(rd_addr), 0);
    chk("t1_n1_busy", 32'(busy), 1); chk("t1_n1_valid", 32'(m_valid), 0);
    tick(); chk("t1_n2_cen", 32'(rd_cen), 0); chk("t1_n2_addr", 32'(rd_addr), 1);
    chk("t1_n2_valid", 32'(m_valid), 0);
    tick(); chk("t1_n3_addr", 32'(rd_addr), 2); beat("t1_n3", 0, 1'b0);
    tick(); chk("t1_n4_addr", 32'(rd_addr), 3); beat("t1_n4", 1, 1'b0);
    tick(); chk("t1_n5_cen", 32'(rd_cen), 1); beat("t1_n5", 2, 1'b0);
    tick(); beat("t1_n6", 3, 1'b1); chk("t1_n6_done", 32'(done), 0);
    tick(); chk("t1_n7_done", 32'(done), 1); chk("t1_n7_valid", 32'(m_valid), 0);
    chk("t1_n7_busy", 32'(busy), 1);
    tick(); chk("t1_n8_done", 32'(done), 0); chk("t1_n8_busy", 32'(busy), 0);

    // base=22, len=4: wrap, plus a start pulse while busy that must be ignored
    base_addr = 12'd22; len = 12'd4; start = 1'b1;
    tick(); start = 1'b0; chk("t2_n1_addr", 32'(rd_addr), 22); chk("t2_n1_cen", 32'(rd_cen), 0);
    tick(); chk("t2_n2_addr", 32'(rd_addr), 23);
    tick(); chk("t2_n3_addr", 32'(rd_addr), 0); beat("t2_n3", 22, 1'b0);
    tick(); chk("t2_n4_addr", 32'(rd_addr), 1); chk("t2_n4_cen", 32'(rd_cen), 0);
    beat("t2_n4", 23, 1'b0);
    base_addr = 12'd3; len = 12'd0; start = 1'b1;
    tick(); start = 1'b0; beat("t2_n5", 0, 1'b0); chk("t2_n5_done", 32'(done), 0);
    tick(); beat("t2_n6", 1, 1'b1);
    tick(); chk("t2_n7_done", 32'(done), 1);
    tick(); chk("t2_n8_done", 32'(done), 0); chk("t2_n8_busy", 32'(busy), 0);
    chk("t2_n8_cen", 32'(rd_cen), 1); chk("t2_n8_valid", 32'(m_valid), 0);

    // len=8 with m_ready pattern 1,0,0,1,...
    base_addr = 12'd10; len = 12'd8; start = 1'b1;
    tick(); start = 1'b0;
    k = 0; issued = 0; acc = 0; hold = 1'b0; held = '0; got_done = 1'b0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (issued - acc == 3) chk("t3_full_stall", 32'(rd_cen), 1);
      if (!rd_cen) begin
        issued++;
        chk("t3_occ_le3", 32'(issued - acc <= 3), 1);
        chk("t3_rd_addr", 32'(rd_addr), 32'(10 + issued - 1));
      end
      if (hold) chk("t3_hold", m_data, held);
      if (done) begin
        got_done = 1'b1;
        break;
      end
      m_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      if (m_valid && m_ready) begin
        chk("t3_data", m_data, memw(10 + k));
        chk("t3_last", 32'(m_last), 32'(k == 7));
        k++; acc++;
      end
      hold = m_valid && !m_ready;
      held = m_data;
      tick();
    end
    chk("t3_done_seen", 32'(got_done), 1);
    chk("t3_beats", k, 8);
    chk("t3_issued", issued, 8);
    m_ready = 1'b1;
    tick(); chk("t3_idle", 32'(busy), 0);

    // len=0
    base_addr = 12'd4; len = 12'd0; start = 1'b1;
    tick(); start = 1'b0;
    chk("t4_n1_done", 32'(done), 1); chk("t4_n1_cen", 32'(rd_cen), 1);
    chk("t4_n1_valid", 32'(m_valid), 0); chk("t4_n1_busy", 32'(busy), 1);
    tick(); chk("t4_n2_done", 32'(done), 0); chk("t4_n2_busy", 32'(busy), 0);
    chk("t4_n2_cen", 32'(rd_cen), 1); chk("t4_n2_valid", 32'(m_valid), 0);

    // reset two cycles after first beat of len=10
    base_addr = 12'd0; len = 12'd10; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    tick(); beat("t5_n3", 0, 1'b0);
    tick();
    tick(); rst = 1'b1;                                             // N+5
    tick(); rst = 1'b0;                                             // N+6
    chk_reset_vals("t5_rst");
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_no_done", 32'(done), 0);
      chk("t5_no_valid", 32'(m_valid), 0);
    end
    base_addr = 12'd5; len = 12'd2; start = 1'b1;
    tick(); start = 1'b0; chk("t5b_n1_addr", 32'(rd_addr), 5);
    tick(); chk("t5b_n2_addr", 32'(rd_addr), 6);
    tick(); beat("t5b_n3", 5, 1'b0);
    tick(); beat("t5b_n4", 6, 1'b1);
    tick(); chk("t5b_n5_done", 32'(done), 1);
    tick(); chk("t5b_n6_busy", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
